// File: rtl/pie_decoder_pkg.sv
// Shared types and default timing constants for the PIE downlink decoder.
package pie_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELIM = 3'd1,
        ST_TARI  = 3'd2,
        ST_RTCAL = 3'd3,
        ST_CAL2  = 3'd4,
        ST_DATA  = 3'd5
    } state_e;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DELIM_MIN   = 1000;
    localparam int DEF_DELIM_MAX   = 1600;
    localparam int DEF_TIMEOUT     = 8000;

endpackage

// File: rtl/pie_decoder_if.sv
// Envelope input and decoded-symbol/calibration outputs of the PIE decoder.
interface pie_decoder_if
    import pie_decoder_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             enabled;
    logic             rx_in;
    logic             frame_start;
    logic             bit_valid;
    logic             bit_data;
    logic             frame_done;
    logic             error;
    logic [CNT_W-1:0] rtcal;
    logic [CNT_W-1:0] trcal;
    logic             trcal_valid;

    modport master (
        output enabled, rx_in,
        input  frame_start, bit_valid, bit_data, frame_done, error,
        input  rtcal, trcal, trcal_valid
    );

    modport slave (
        input  enabled, rx_in,
        output frame_start, bit_valid, bit_data, frame_done, error,
        output rtcal, trcal, trcal_valid
    );

endinterface

// File: rtl/pie_decoder_edge_sync.sv
// Synchronises the async envelope and emits registered rise/fall pulses plus the
// synchronised level aligned with those pulses.
module pie_edge_sync
    import pie_decoder_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_i,
    output logic rise_o,
    output logic fall_o,
    output logic level_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    // Idle line is CW (high), so preset high to avoid a spurious edge out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign level_o = prev_q;

endmodule

// File: rtl/pie_decoder.sv
// EPC Gen2 PIE downlink decoder: measures rising-to-rising intervals to extract
// delimiter, Tari, RTcal, optional TRcal and data bits.
module pie_decoder
    import pie_decoder_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DELIM_MIN   = DEF_DELIM_MIN,
    parameter int DELIM_MAX   = DEF_DELIM_MAX,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         reset,
    pie_decoder_if.slave bus
);

    localparam logic [CNT_W-1:0] DMIN = CNT_W'(DELIM_MIN);
    localparam logic [CNT_W-1:0] DMAX = CNT_W'(DELIM_MAX);
    localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);

    logic rise;
    logic fall;
    logic level;

    pie_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk     (clk),
        .reset   (reset),
        .rx_i    (bus.rx_in),
        .rise_o  (rise),
        .fall_o  (fall),
        .level_o (level)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tari_q, tari_d;
    logic [CNT_W-1:0] rtcal_q, rtcal_d;
    logic [CNT_W-1:0] trcal_q, trcal_d;
    logic             trcal_valid_q, trcal_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             bit_valid_q, bit_valid_d;
    logic             bit_data_q, bit_data_d;
    logic             frame_done_q, frame_done_d;
    logic             error_q, error_d;
    logic             fail;
    logic             take_bit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Pivot is RTcal/2; an interval exactly on the pivot decodes as 0.
    function automatic logic bit_of(input logic [CNT_W-1:0] n, input logic [CNT_W-1:0] rt);
        return n > (rt >> 1);
    endfunction

    // Intervals are rising-to-rising; the delimiter alone is timed from its falling edge.
    assign cnt_d = (rise || (fall && state_q == ST_IDLE)) ? CNT_W'(1) : sat_inc(cnt_q);

    always_comb begin
        state_d       = state_q;
        tari_d        = tari_q;
        rtcal_d       = rtcal_q;
        trcal_d       = trcal_q;
        trcal_valid_d = trcal_valid_q;
        frame_start_d = 1'b0;
        bit_valid_d   = 1'b0;
        bit_data_d    = bit_data_q;
        frame_done_d  = 1'b0;
        error_d       = 1'b0;
        fail          = 1'b0;
        take_bit      = 1'b0;

        if (!bus.enabled) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (fall) state_d = ST_DELIM;
                end
                ST_DELIM: begin
                    if (rise) begin
                        if (cnt_q >= DMIN && cnt_q <= DMAX) state_d = ST_TARI;
                        else fail = 1'b1;
                    end else if (cnt_q > TMO) begin
                        fail = 1'b1;
                    end
                end
                ST_TARI: begin
                    if (rise) begin
                        tari_d  = cnt_q;
                        state_d = ST_RTCAL;
                    end else if (cnt_q > TMO) begin
                        fail = 1'b1;
                    end
                end
                ST_RTCAL: begin
                    if (rise) begin
                        if (cnt_q <= tari_q) begin
                            fail = 1'b1;
                        end else begin
                            rtcal_d       = cnt_q;
                            trcal_valid_d = 1'b0;
                            frame_start_d = 1'b1;
                            state_d       = ST_CAL2;
                        end
                    end else if (cnt_q > TMO) begin
                        fail = 1'b1;
                    end
                end
                ST_CAL2: begin
                    // Without TRcal (frame-sync) this symbol is already the first data bit.
                    if (rise) begin
                        state_d = ST_DATA;
                        if (cnt_q > rtcal_q) begin
                            trcal_d       = cnt_q;
                            trcal_valid_d = 1'b1;
                        end else begin
                            take_bit = 1'b1;
                        end
                    end else if (cnt_q > TMO) begin
                        fail = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rise) begin
                        take_bit = 1'b1;
                    end else if (cnt_q > rtcal_q) begin
                        if (level) begin
                            frame_done_d  = 1'b1;
                            trcal_valid_d = 1'b0;
                            state_d       = ST_IDLE;
                        end else begin
                            fail = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (take_bit) begin
                if (cnt_q >= rtcal_q) begin
                    fail = 1'b1;
                end else begin
                    bit_valid_d = 1'b1;
                    bit_data_d  = bit_of(cnt_q, rtcal_q);
                end
            end

            if (fail) begin
                error_d       = 1'b1;
                trcal_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            rtcal_q       <= '0;
            trcal_q       <= '0;
            trcal_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
            bit_valid_q   <= 1'b0;
            bit_data_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rtcal_q       <= rtcal_d;
            trcal_q       <= trcal_d;
            trcal_valid_q <= trcal_valid_d;
            frame_start_q <= frame_start_d;
            bit_valid_q   <= bit_valid_d;
            bit_data_q    <= bit_data_d;
            frame_done_q  <= frame_done_d;
            error_q       <= error_d;
        end
    end

    // Tari is only read after it has been captured, so it needs no reset.
    always_ff @(posedge clk) begin
        tari_q <= tari_d;
    end

    assign bus.frame_start = frame_start_q;
    assign bus.bit_valid   = bit_valid_q;
    assign bus.bit_data    = bit_data_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.error       = error_q;
    assign bus.rtcal       = rtcal_q;
    assign bus.trcal       = trcal_q;
    assign bus.trcal_valid = trcal_valid_q;

endmodule

// File: tb/tb_pie_decoder.sv
// Bench for pie_decoder: table-driven frames, random frames against an interval-list
// reference model, and hand-written reset / enable sequences.
module tb_pie_decoder;
    import pie_decoder_pkg::*;

    localparam int PW = 300;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pie_decoder_if #(.CNT_W(16)) bus ();

    pie_decoder #(
        .CNT_W       (16),
        .SYNC_STAGES (2),
        .DELIM_MIN   (DEF_DELIM_MIN),
        .DELIM_MAX   (DEF_DELIM_MAX),
        .TIMEOUT     (DEF_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [15:0]       delim;
        logic [3:0]        nsym;
        logic [0:7][15:0]  sym;
        logic [15:0]       tail;
    } stim_t;

    typedef struct packed {
        logic [3:0]  fs;
        logic [3:0]  nb;
        logic [7:0]  bits;
        logic [15:0] rt;
        logic [15:0] tr;
        logic        tv;
        logic [3:0]  fd;
        logic [3:0]  er;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } row_t;

    int n_cmp = 0;
    int n_bad = 0;

    int fs_tot = 0, bv_tot = 0, fd_tot = 0, er_tot = 0, ov_tot = 0;
    logic bit_log [0:255];
    logic tv_log  [0:255];
    int b_fs, b_bv, b_fd, b_er, b_ov;
    int m_rt, m_tr;

    always @(negedge clk) begin
        if (bus.frame_start) fs_tot <= fs_tot + 1;
        if (bus.frame_done)  fd_tot <= fd_tot + 1;
        if (bus.error)       er_tot <= er_tot + 1;
        if (bus.bit_valid) begin
            bit_log[bv_tot % 256] <= bus.bit_data;
            tv_log[bv_tot % 256]  <= bus.trcal_valid;
            bv_tot <= bv_tot + 1;
        end
        if (int'(bus.frame_start) + int'(bus.bit_valid) + int'(bus.frame_done) + int'(bus.error) > 1)
            ov_tot <= ov_tot + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wcyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sym(input int n);
        bus.rx_in = 1'b1;
        wcyc(n - PW);
        bus.rx_in = 1'b0;
        wcyc(PW);
        bus.rx_in = 1'b1;
    endtask

    task automatic run_frame(input stim_t s);
        bus.rx_in = 1'b0;
        wcyc(int'(s.delim));
        bus.rx_in = 1'b1;
        for (int i = 0; i < int'(s.nsym); i++) sym(int'(s.sym[i]));
        wcyc(int'(s.tail));
    endtask

    task automatic snap();
        b_fs = fs_tot;
        b_bv = bv_tot;
        b_fd = fd_tot;
        b_er = er_tot;
        b_ov = ov_tot;
    endtask

    task automatic check_frame(input string tag, input exp_t e);
        chk({tag, " frame_start"}, fs_tot - b_fs, int'(e.fs));
        chk({tag, " bit_count"}, bv_tot - b_bv, int'(e.nb));
        for (int i = 0; i < int'(e.nb); i++)
            chk($sformatf("%s bit%0d", tag, i), int'(bit_log[(b_bv + i) % 256]), int'(e.bits[i]));
        chk({tag, " rtcal"}, int'(bus.rtcal), int'(e.rt));
        chk({tag, " trcal"}, int'(bus.trcal), int'(e.tr));
        if (e.nb != 0)
            chk({tag, " trcal_valid"}, int'(tv_log[(b_bv + int'(e.nb) - 1) % 256]), int'(e.tv));
        chk({tag, " frame_done"}, fd_tot - b_fd, int'(e.fd));
        chk({tag, " error"}, er_tot - b_er, int'(e.er));
        chk({tag, " pulse_overlap"}, ov_tot - b_ov, 0);
    endtask

    function automatic stim_t mks(input int delim, input int a, input int b, input int c,
                                  input int d, input int f, input int g, input int tail);
        stim_t s;
        int v [6];
        s = '0;
        s.delim = 16'(delim);
        s.tail  = 16'(tail);
        v[0] = a; v[1] = b; v[2] = c; v[3] = d; v[4] = f; v[5] = g;
        for (int i = 0; i < 6; i++) begin
            if (v[i] != 0) begin
                s.sym[int'(s.nsym)] = 16'(v[i]);
                s.nsym = s.nsym + 4'd1;
            end
        end
        return s;
    endfunction

    function automatic exp_t mke(input int fs, input int nb, input logic [7:0] bits, input int rt,
                                 input int tr, input int tv, input int fd, input int er);
        exp_t e;
        e.fs = 4'(fs); e.nb = 4'(nb); e.bits = bits; e.rt = 16'(rt); e.tr = 16'(tr);
        e.tv = tv[0]; e.fd = 4'(fd); e.er = 4'(er);
        return e;
    endfunction

    // Reference: walk the list of intervals that make up one frame.
    function automatic exp_t model(input stim_t s, input int prev_rt, input int prev_tr);
        exp_t e;
        int rt, first, nb, iv;
        logic tv;
        e = '0;
        e.rt = 16'(prev_rt);
        e.tr = 16'(prev_tr);
        if (int'(s.delim) < DEF_DELIM_MIN || int'(s.delim) > DEF_DELIM_MAX) begin
            e.er = 4'd1;
            return e;
        end
        if (int'(s.sym[1]) <= int'(s.sym[0])) begin
            e.er = 4'd1;
            return e;
        end
        rt = int'(s.sym[1]);
        e.fs = 4'd1;
        e.rt = 16'(rt);
        tv = 1'b0;
        first = 2;
        nb = 0;
        if (int'(s.nsym) > 2 && int'(s.sym[2]) > rt) begin
            e.tr = s.sym[2];
            tv = 1'b1;
            first = 3;
        end
        for (int i = first; i < int'(s.nsym); i++) begin
            iv = int'(s.sym[i]);
            if (iv >= rt) begin
                e.er = 4'd1;
                return e;
            end
            e.bits[nb] = (2 * iv > rt);
            nb++;
            e.nb = 4'(nb);
            e.tv = tv;
        end
        e.fd = 4'd1;
        return e;
    endfunction

    initial begin
        row_t  rows [5];
        stim_t s;
        exp_t  e;
        int    tari, rt, n, k, iv;

        bus.enabled = 1'b1;
        bus.rx_in   = 1'b1;
        reset       = 1'b1;
        m_rt = 0;
        m_tr = 0;

        rows[0].s = mks(1250, 625, 1719, 3000, 1094, 625, 0, 2000);
        rows[0].e = mke(1, 2, 8'b01, 1719, 3000, 1, 1, 0);
        rows[1].s = mks(1250, 625, 1719, 625, 1094, 0, 0, 1800);
        rows[1].e = mke(1, 2, 8'b10, 1719, 3000, 0, 1, 0);
        rows[2].s = mks(800, 0, 0, 0, 0, 0, 0, 100);
        rows[2].e = mke(0, 0, 8'b0, 1719, 3000, 0, 0, 1);
        rows[3].s = mks(1700, 0, 0, 0, 0, 0, 0, 100);
        rows[3].e = mke(0, 0, 8'b0, 1719, 3000, 0, 0, 1);
        rows[4].s = mks(1250, 625, 1719, 625, 859, 860, 1719, 100);
        rows[4].e = mke(1, 3, 8'b100, 1719, 3000, 0, 0, 1);

        wcyc(5);
        reset = 1'b0;
        wcyc(2);
        chk("reset frame_start", int'(bus.frame_start), 0);
        chk("reset bit_valid", int'(bus.bit_valid), 0);
        chk("reset bit_data", int'(bus.bit_data), 0);
        chk("reset frame_done", int'(bus.frame_done), 0);
        chk("reset error", int'(bus.error), 0);
        chk("reset rtcal", int'(bus.rtcal), 0);
        chk("reset trcal", int'(bus.trcal), 0);
        chk("reset trcal_valid", int'(bus.trcal_valid), 0);

        for (int i = 0; i < 5; i++) begin
            snap();
            run_frame(rows[i].s);
            check_frame($sformatf("row%0d", i), rows[i].e);
            m_rt = int'(rows[i].e.rt);
            m_tr = int'(rows[i].e.tr);
        end

        for (int r = 0; r < 2; r++) begin
            s = '0;
            s.delim = 16'($urandom_range(1650, 950));
            if (int'(s.delim) >= DEF_DELIM_MIN && int'(s.delim) <= DEF_DELIM_MAX) begin
                tari = int'($urandom_range(500, 350));
                rt   = tari * 5 / 2 + int'($urandom_range(tari / 2, 0));
                s.sym[0] = 16'(tari);
                s.sym[1] = 16'(rt);
                n = 2;
                if ($urandom_range(1, 0) == 1) begin
                    s.sym[n] = 16'(rt + 1 + int'($urandom_range(rt / 2, 0)));
                    n++;
                end
                for (int b = 0; b < 3; b++) begin
                    k = int'($urandom_range(3, 0));
                    case (k)
                        0:       iv = tari;
                        1:       iv = rt / 2;
                        2:       iv = rt / 2 + 1;
                        default: iv = int'($urandom_range(rt + 50, rt / 2 + 1));
                    endcase
                    s.sym[n] = 16'(iv);
                    n++;
                end
                s.nsym = 4'(n);
                s.tail = 16'(rt + 100);
            end else begin
                s.tail = 16'd200;
            end
            e = model(s, m_rt, m_tr);
            snap();
            run_frame(s);
            check_frame($sformatf("rand%0d", r), e);
            m_rt = int'(e.rt);
            m_tr = int'(e.tr);
        end

        // Reset pulse while the decoder sits in DATA.
        snap();
        bus.rx_in = 1'b0;
        wcyc(1250);
        bus.rx_in = 1'b1;
        sym(625);
        sym(1719);
        sym(625);
        wcyc(100);
        chk("rstseq frame_start", fs_tot - b_fs, 1);
        chk("rstseq bit_count", bv_tot - b_bv, 1);
        chk("rstseq bit0", int'(bit_log[b_bv % 256]), 0);
        reset = 1'b1;
        wcyc(1);
        reset = 1'b0;
        chk("rstseq rtcal", int'(bus.rtcal), 0);
        chk("rstseq trcal", int'(bus.trcal), 0);
        chk("rstseq trcal_valid", int'(bus.trcal_valid), 0);
        chk("rstseq bit_data", int'(bus.bit_data), 0);
        chk("rstseq pulses", int'({bus.frame_start, bus.bit_valid, bus.frame_done, bus.error}), 0);
        wcyc(20);
        snap();
        run_frame(mks(1250, 625, 1719, 1094, 0, 0, 0, 1800));
        check_frame("rstseq_frame", mke(1, 1, 8'b1, 1719, 0, 0, 1, 0));

        // Disable mid-frame, then re-enable for a fresh frame.
        snap();
        bus.rx_in = 1'b0;
        wcyc(1250);
        bus.rx_in = 1'b1;
        sym(625);
        sym(1719);
        sym(3000);
        sym(1094);
        wcyc(20);
        chk("ens bit_count", bv_tot - b_bv, 1);
        chk("ens bit0", int'(bit_log[b_bv % 256]), 1);
        chk("ens trcal_valid", int'(bus.trcal_valid), 1);
        bus.enabled = 1'b0;
        snap();
        sym(625);
        wcyc(1800);
        chk("ens_off frame_start", fs_tot - b_fs, 0);
        chk("ens_off bit_count", bv_tot - b_bv, 0);
        chk("ens_off frame_done", fd_tot - b_fd, 0);
        chk("ens_off error", er_tot - b_er, 0);
        chk("ens_off rtcal", int'(bus.rtcal), 1719);
        chk("ens_off trcal", int'(bus.trcal), 3000);
        chk("ens_off trcal_valid", int'(bus.trcal_valid), 1);
        bus.enabled = 1'b1;
        wcyc(10);
        snap();
        run_frame(mks(1250, 625, 1500, 900, 0, 0, 0, 1600));
        check_frame("ens_frame", mke(1, 1, 8'b1, 1500, 3000, 0, 1, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
